// File: rtl/muldiv_sequencer_pkg.sv
// rtl/muldiv_sequencer_pkg.sv - shared ALU codes, op encodings and sequencer states
package muldiv_sequencer_pkg;

   localparam int ALU_DATA_WIDTH    = 32;
   localparam int ALU_CONTROL_WIDTH = 4;

   localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_ADD = 4'b0010;
   localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_SUB = 4'b0110;

   typedef enum logic [1:0] {
      MD_OP_MUL   = 2'b00,
      MD_OP_MULHU = 2'b01,
      MD_OP_DIVU  = 2'b10,
      MD_OP_REMU  = 2'b11
   } md_op_t;

   typedef enum logic [1:0] {
      MD_ST_IDLE = 2'b00,
      MD_ST_MUL  = 2'b01,
      MD_ST_DIV  = 2'b10,
      MD_ST_DONE = 2'b11
   } md_state_t;

endpackage

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle unsigned mul/div controller reusing the EX-stage ALU
import muldiv_sequencer_pkg::*;

module muldiv_sequencer #(
   parameter int WIDTH = ALU_DATA_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [1:0]                   op,
   input  logic [WIDTH-1:0]             src_a,
   input  logic [WIDTH-1:0]             src_b,
   input  logic                         flush,
   output logic                         ready,
   output logic                         busy,
   output logic                         done,
   output logic [WIDTH-1:0]             result,
   output logic [WIDTH-1:0]             alu_a,
   output logic [WIDTH-1:0]             alu_b,
   output logic [ALU_CONTROL_WIDTH-1:0] alu_ctrl,
   input  logic [WIDTH-1:0]             alu_result
);

   md_state_t        state;
   md_op_t           op_q;
   logic [CNT_W-1:0] counter;

   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] mplier_lo;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] divisor;

   logic             mul_carry;
   logic [WIDTH-1:0] mul_acc_nxt;
   logic [WIDTH-1:0] mul_lo_nxt;

   logic             div_msb;
   logic [WIDTH-1:0] rem_sh;
   logic             div_ge;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] quo_nxt;

   logic             last_iter;

   // ALU ports are only meaningful while busy; park them at ADD 0+0 otherwise
   always_comb begin
      alu_ctrl = ALU_ADD;
      alu_a    = '0;
      alu_b    = '0;
      case (state)
         MD_ST_MUL: begin
            alu_a = acc_hi;
            alu_b = mplier_lo[0] ? mcand : '0;
         end
         MD_ST_DIV: begin
            alu_ctrl = ALU_SUB;
            alu_a    = rem_sh;
            alu_b    = divisor;
         end
         default: ;
      endcase
   end

   // Shift-add step: the ADD carry-out is recovered by an unsigned wrap test
   assign mul_carry   = (alu_result < acc_hi);
   assign mul_acc_nxt = {mul_carry, alu_result[WIDTH-1:1]};
   assign mul_lo_nxt  = {alu_result[0], mplier_lo[WIDTH-1:1]};

   // Restoring step: div_msb covers shifted remainders that overflow WIDTH bits
   assign div_msb = rem[WIDTH-1];
   assign rem_sh  = {rem[WIDTH-2:0], quo[WIDTH-1]};
   assign div_ge  = div_msb | (rem_sh >= divisor);
   assign rem_nxt = div_ge ? alu_result : rem_sh;
   assign quo_nxt = {quo[WIDTH-2:0], div_ge};

   assign last_iter = (counter == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= MD_ST_IDLE;
         op_q      <= MD_OP_MUL;
         counter   <= '0;
         acc_hi    <= '0;
         mplier_lo <= '0;
         mcand     <= '0;
         rem       <= '0;
         quo       <= '0;
         divisor   <= '0;
         ready     <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
      end else begin
         done <= 1'b0;
         if (flush) begin
            state <= MD_ST_IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
         end else begin
            case (state)
               MD_ST_IDLE, MD_ST_DONE: begin
                  if (start) begin
                     op_q      <= md_op_t'(op);
                     counter   <= '0;
                     acc_hi    <= '0;
                     mplier_lo <= src_b;
                     mcand     <= src_a;
                     rem       <= '0;
                     quo       <= src_a;
                     divisor   <= src_b;
                     if (!op[1]) begin
                        state <= MD_ST_MUL;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                     end else if (src_b != '0) begin
                        state <= MD_ST_DIV;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                     end else begin
                        // divide by zero resolves immediately without iterating
                        state  <= MD_ST_DONE;
                        ready  <= 1'b1;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= (md_op_t'(op) == MD_OP_DIVU) ? '1 : src_a;
                     end
                  end else begin
                     state <= MD_ST_IDLE;
                     ready <= 1'b1;
                     busy  <= 1'b0;
                  end
               end
               MD_ST_MUL: begin
                  acc_hi    <= mul_acc_nxt;
                  mplier_lo <= mul_lo_nxt;
                  counter   <= counter + CNT_W'(1);
                  if (last_iter) begin
                     state  <= MD_ST_DONE;
                     ready  <= 1'b1;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     result <= (op_q == MD_OP_MUL) ? mul_lo_nxt : mul_acc_nxt;
                  end
               end
               MD_ST_DIV: begin
                  rem     <= rem_nxt;
                  quo     <= quo_nxt;
                  counter <= counter + CNT_W'(1);
                  if (last_iter) begin
                     state  <= MD_ST_DONE;
                     ready  <= 1'b1;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     result <= (op_q == MD_OP_DIVU) ? quo_nxt : rem_nxt;
                  end
               end
               default: begin
                  state <= MD_ST_IDLE;
                  ready <= 1'b1;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
   import muldiv_sequencer_pkg::*;

   localparam int W = 32;

   logic                         clk = 1'b0;
   logic                         rst;
   logic                         start;
   logic                         flush;
   logic [1:0]                   op;
   logic [W-1:0]                 src_a;
   logic [W-1:0]                 src_b;
   logic                         ready;
   logic                         busy;
   logic                         done;
   logic [W-1:0]                 result;
   logic [W-1:0]                 alu_a;
   logic [W-1:0]                 alu_b;
   logic [ALU_CONTROL_WIDTH-1:0] alu_ctrl;
   logic [W-1:0]                 alu_result;

   int errors = 0;
   int checks = 0;
   int bad_mul_ctrl = 0;
   int bad_div_ctrl = 0;
   logic [1:0] cur_op = 2'b00;

   always #5 clk = ~clk;

   // stand-in for the external single-cycle ALU
   assign alu_result = (alu_ctrl == ALU_ADD) ? alu_a + alu_b :
                       (alu_ctrl == ALU_SUB) ? alu_a - alu_b : '0;

   muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
      .flush(flush), .ready(ready), .busy(busy), .done(done), .result(result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result)
   );

   always @(negedge clk) begin
      if (busy === 1'b1) begin
         if (!cur_op[1] && alu_ctrl !== ALU_ADD) bad_mul_ctrl++;
         if (cur_op[1] && alu_ctrl !== ALU_SUB) bad_div_ctrl++;
      end
   end

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // called at a negedge; returns just after the accepting edge
   task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      op = o; src_a = a; src_b = b; cur_op = o;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output logic busy1);
      cyc = 0;
      busy1 = 1'b0;
      repeat (60) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) busy1 = busy;
         if (done === 1'b1) return;
      end
      cyc = -1;
   endtask

   task automatic run(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
      int   cyc;
      logic busy1;
      issue(o, a, b);
      wait_done(cyc, busy1);
      check({tag, "_latency"}, W'(cyc), W'(lat));
      check({tag, "_result"}, result, exp);
      check({tag, "_busy"}, {31'd0, busy1}, {31'd0, lat > 1});
      @(negedge clk);
      check({tag, "_pulse"}, {31'd0, done}, 32'd0);
   endtask

   initial begin : stim
      int   cyc;
      int   extra_done;
      logic busy1;

      rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
      repeat (2) @(negedge clk);
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_alu_ctrl", W'(alu_ctrl), W'(ALU_ADD));
      check("rst_alu_a", alu_a, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run("mul_7x6",      2'b00, 32'd7,          32'd6,          32'd42,         33);
      run("mulhu_ffxff",  2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33);
      run("mul_ffxff",    2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  33);
      run("mulhu_8000x4", 2'b01, 32'h8000_0000,  32'd4,          32'd2,          33);
      run("divu_100_7",   2'b10, 32'd100,        32'd7,          32'd14,         33);
      run("remu_100_7",   2'b11, 32'd100,        32'd7,          32'd2,          33);
      run("divu_8000_3",  2'b10, 32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  33);
      run("remu_8000_3",  2'b11, 32'h8000_0000,  32'd3,          32'd2,          33);
      run("divu_big",     2'b10, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          33);
      run("remu_big",     2'b11, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  33);
      run("divu_by0",     2'b10, 32'd5,          32'd0,          32'hFFFF_FFFF,  1);
      run("remu_by0",     2'b11, 32'd5,          32'd0,          32'd5,          1);
      check("idle_alu_b", alu_b, 32'd0);

      // flush at iteration 10 of a divide
      issue(2'b10, 32'd1000, 32'd3);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_ready", {31'd0, ready}, 32'd1);
      check("flush_busy", {31'd0, busy}, 32'd0);
      check("flush_done", {31'd0, done}, 32'd0);
      check("flush_result", result, 32'd5);
      extra_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) extra_done++;
      end
      check("flush_no_done", W'(extra_done), 32'd0);

      // flush wins over start in the same cycle
      op = 2'b00; src_a = 32'd2; src_b = 32'd2; cur_op = 2'b00;
      start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush_prio_busy", {31'd0, busy}, 32'd0);
      check("flush_prio_ready", {31'd0, ready}, 32'd1);

      // asynchronous reset mid-multiply, sampled before the next clock edge
      issue(2'b00, 32'd3, 32'd5);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_ready", {31'd0, ready}, 32'd1);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_done", {31'd0, done}, 32'd0);
      check("arst_result", result, 32'd0);
      check("arst_alu_a", alu_a, 32'd0);
      check("arst_alu_b", alu_b, 32'd0);
      check("arst_alu_ctrl", W'(alu_ctrl), W'(ALU_ADD));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // back-to-back: second start issued in the DONE cycle of the first
      issue(2'b00, 32'd3, 32'd3);
      wait_done(cyc, busy1);
      check("b2b_mul_latency", W'(cyc), 32'd33);
      check("b2b_mul_result", result, 32'd9);
      op = 2'b10; src_a = 32'd9; src_b = 32'd3; cur_op = 2'b10;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = -1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (i == 5) begin
            op = 2'b00; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF; start = 1'b1;
         end
         if (i == 6) start = 1'b0;
         if (done === 1'b1) begin
            cyc = i;
            break;
         end
      end
      check("b2b_div_gap", W'(cyc), 32'd33);
      check("b2b_div_result", result, 32'd3);
      @(negedge clk);
      check("b2b_pulse", {31'd0, done}, 32'd0);
      check("b2b_idle_ready", {31'd0, ready}, 32'd1);

      check("mul_alu_add_only", W'(bad_mul_ctrl), 32'd0);
      check("div_alu_sub_only", W'(bad_div_ctrl), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller for the EX stage that runs unsigned multiply and divide instructions on the existing single-cycle ALU.
- It drives the ALU with the ALU_ADD and ALU_SUB control codes, one iteration per cycle, and stalls the pipeline until the result is ready.
- It sits beside the ALU. An EX-stage mux gives the ALU ports to this block while busy is high.

Parameters:
- WIDTH, default 32 (equal to ALU_DATA_WIDTH): operand and result width.
- CNT_W, default 6: iteration counter width. Must hold the value WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only when ready=1
- op  in  2  operation: 00=MUL (low word), 01=MULHU (high word), 10=DIVU, 11=REMU
- src_a  in  WIDTH  multiplicand or dividend
- src_b  in  WIDTH  multiplier or divisor
- flush  in  1  abort the current operation (pipeline flush)
- ready  out  1  high in IDLE and DONE
- busy  out  1  high in MUL_IT and DIV_IT; used as the pipeline stall
- done  out  1  one-cycle pulse when result becomes valid
- result  out  WIDTH  result of the last completed operation; held until the next done
- alu_a  out  WIDTH  ALU input_data_1
- alu_b  out  WIDTH  ALU input_data_2
- alu_ctrl  out  ALU_CONTROL_WIDTH  ALU control code
- alu_result  in  WIDTH  ALU output_data (combinational, same cycle)

Behaviour:
- Reset (asynchronous): state=IDLE; ready=1; busy=0; done=0; result=0; counter=0; internal registers cleared.
- States are IDLE, MUL_IT, DIV_IT and DONE.
  - IDLE, start=1: latch op, src_a and src_b; counter=0.
    - MUL/MULHU go to MUL_IT.
    - DIVU/REMU with src_b≠0 go to DIV_IT.
    - DIVU/REMU with src_b=0 go to DONE with result = all ones (DIVU) or src_a (REMU).
  - MUL_IT: shift-add, LSB-first. Registers: acc_hi, mplier_lo, mcand.
    - alu_ctrl=ALU_ADD, alu_a=acc_hi, alu_b = mplier_lo[0] ? mcand : 0.
    - carry = (alu_result < alu_a), unsigned.
    - {acc_hi, mplier_lo} <= {carry, alu_result, mplier_lo} >> 1.
    - counter increments; after WIDTH iterations go to DONE.
  - DIV_IT: restoring division, MSB-first. Registers: rem, quo (initialised to dividend).
    - {msb, rem_sh} = {rem, quo[WIDTH-1]}.
    - alu_ctrl=ALU_SUB, alu_a=rem_sh, alu_b=divisor.
    - ge = msb | (rem_sh >= divisor). The comparison is a local comparator; no ALU borrow is used.
    - rem <= ge ? alu_result : rem_sh; quo <= {quo[WIDTH-2:0], ge}.
    - After WIDTH iterations go to DONE.
  - DONE: done=1 for exactly this cycle.
    - result = acc/mplier low word (MUL), acc_hi (MULHU), quo (DIVU) or rem (REMU).
    - result is registered on the DONE entry edge.
    - A start in DONE is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- Latency: start accepted at edge 0 → done high in cycle WIDTH+1 (33 for WIDTH=32). Divide-by-zero: done in cycle 1.
- ALU outputs outside MUL_IT/DIV_IT: alu_ctrl=ALU_ADD, alu_a=0, alu_b=0.
- flush=1 in any state: next state IDLE; no done pulse; result keeps its previous value.
  - flush has priority over start in the same cycle.
- start while busy: ignored (ready=0).
- Arithmetic is unsigned throughout, and counter wrap cannot occur. The MUL low word is {acc_hi, mplier_lo} low half after the final shift.

Decomposition:
- const.v carries:
  - ALU_DATA_WIDTH, ALU_CONTROL_WIDTH, ALU_ADD, ALU_SUB (existing);
  - new MD_OP_MUL, MD_OP_MULHU, MD_OP_DIVU, MD_OP_REMU;
  - new MD_ST_IDLE, MD_ST_MUL, MD_ST_DIV, MD_ST_DONE.
- No sub-module. The ALU stays external and is instantiated once in EX, with an EX-level mux selected by busy.

Test Plan:
- MUL 7 × 6: start op=00, a=7, b=6 → busy for 32 cycles, done in cycle 33, result=42; ALU only ever sees ADD.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → result=0xFFFFFFFE. The same operands with MUL → result=0x00000001 (checks the carry path).
- DIVU 100 / 7 → result=14. REMU 100 / 7 → result=2. DIVU 0x80000000 / 3 → 0x2AAAAAAA.
- Divide by zero:
  - DIVU 5 / 0 → done in cycle 1, result=0xFFFFFFFF.
  - REMU 5 / 0 → result=5.
- Flush and async reset:
  - DIVU started; flush at iteration 10 → IDLE next cycle, no done, result unchanged.
  - Async rst pulse mid-MUL → all outputs at reset values immediately.
- Back-to-back: start asserted in the DONE cycle (MUL 3 × 3 then DIVU 9 / 3) → two done pulses 33 cycles apart, results 9 then 3. A start while busy is ignored.
